// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types for the data-memory responder and its posted-write buffer.
package riscv_pkg;
  localparam int DMEM_BE_W = 4;
  localparam int DMEM_XLEN = 32;
  // Word-index width of a buffered store; DEPTH_WORDS must not exceed 2**DMEM_IDX_W.
  localparam int DMEM_IDX_W = 8;
  typedef enum logic {IDLE, READ_WAIT} dmem_state_e;
  typedef struct packed {
    logic [DMEM_IDX_W-1:0] idx;
    logic [DMEM_BE_W-1:0]  be;
    logic [DMEM_XLEN-1:0]  data;
  } dmem_wbuf_entry_t;
endpackage

// File: rtl/dmem_wbuf.sv
// dmem_wbuf: circular FIFO holding posted stores until the array is free to take them.
module dmem_wbuf #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp, rp;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  assign dout  = mem[rp];
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data-memory responder with posted stores and fixed-latency loads.
module dmem_responder
  import riscv_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WBUF_DEPTH  = 4,
  parameter int RD_LATENCY  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [XLEN-1:0]      req_addr,
  input  logic [DMEM_BE_W-1:0] req_be,
  input  logic [XLEN-1:0]      req_wdata,
  output logic                 rsp_valid,
  output logic [XLEN-1:0]      rsp_rdata,
  output logic                 rsp_err,
  output logic                 wr_err,
  output logic                 wbuf_empty
);
  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(WBUF_DEPTH) + 1;
  logic [XLEN-1:0]  mem [DEPTH_WORDS];
  dmem_state_e      state;
  logic [1:0]       cnt;
  logic [XLEN-1:0]  rd_data, ld_data;
  logic             rd_err;
  logic [IW-1:0]    idx;
  logic             oor, idle, xfer, st_acc, ld_acc, push, pop, full, empty;
  logic [CW-1:0]    count;
  dmem_wbuf_entry_t head, entry;
  assign idx     = req_addr[IW+1:2];
  assign oor     = |req_addr[XLEN-1:IW+2];
  assign idle    = state == IDLE;
  // Loads wait for an empty buffer, which keeps store->load ordering without forwarding.
  assign req_ready  = rst_n && idle && (req_we ? !full : empty);
  assign xfer       = req_valid && req_ready;
  assign st_acc     = xfer && req_we;
  assign ld_acc     = xfer && !req_we;
  assign push       = st_acc && !oor;
  assign pop        = idle && !empty;
  assign wbuf_empty = count == '0;
  assign entry      = '{idx: DMEM_IDX_W'(idx), be: req_be, data: req_wdata};
  assign ld_data    = oor ? '0 : mem[idx];
  dmem_wbuf #(.W($bits(dmem_wbuf_entry_t)), .DEPTH(WBUF_DEPTH)) u_wbuf (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(entry),
    .dout(head), .full(full), .empty(empty), .count(count)
  );
  always_ff @(posedge clk)
    if (pop)
      for (int b = 0; b < DMEM_BE_W; b++)
        if (head.be[b]) mem[head.idx[IW-1:0]][8*b+:8] <= head.data[8*b+:8];
  // The response registers load one cycle before the edge that consumes them.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rd_data   <= '0;
      rd_err    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      if (st_acc && oor) wr_err <= 1'b1;
      if (idle) begin
        if (ld_acc) begin
          state   <= READ_WAIT;
          cnt     <= 2'(RD_LATENCY - 1);
          rd_data <= ld_data;
          rd_err  <= oor;
          if (RD_LATENCY == 1) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= ld_data;
            rsp_err   <= oor;
          end
        end
      end else if (cnt == '0) begin
        state <= IDLE;
      end else begin
        cnt <= cnt - 1'b1;
        if (cnt == 2'd1) begin
          rsp_valid <= 1'b1;
          rsp_rdata <= rd_data;
          rsp_err   <= rd_err;
        end
      end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of dmem_responder against a behavioural model.
module tb_dmem_responder;
  localparam int L  = 2;
  localparam int WB = 4;
  logic        clk = 0, rst_n = 0, req_valid = 0, req_we = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [3:0]  req_be = 0;
  logic        req_ready, rsp_valid, rsp_err, wr_err, wbuf_empty;
  logic [31:0] rsp_rdata;
  int          n_chk = 0, n_fail = 0;
  logic [31:0] m_mem [256];
  bit          m_wr [256];
  int          pend = 0, busy = 0;
  bit          m_wr_err = 0, exp_err = 0, exp_known = 0, got_rsp = 0, last_err = 0;
  logic [31:0] exp_data = 0, last_rdata = 0;

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wr_err(wr_err), .wbuf_empty(wbuf_empty)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive, compare outputs with the model, then advance the model over the edge.
  task automatic cycle(input bit v, input bit we, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] d, output bit acc);
    int  i;
    bit  o, drain, exp_rdy;
    @(negedge clk);
    req_valid = v; req_we = we; req_addr = a; req_be = be; req_wdata = d;
    #1;
    exp_rdy = (busy == 0) && (we ? pend < WB : pend == 0);
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("rsp_valid", 32'(rsp_valid), 32'(busy == 1));
    if (busy == 1) begin
      got_rsp = 1; last_rdata = rsp_rdata; last_err = rsp_err;
      check("rsp_err", 32'(rsp_err), 32'(exp_err));
      if (exp_known) check("rsp_rdata", rsp_rdata, exp_data);
    end
    check("wbuf_empty", 32'(wbuf_empty), 32'(pend == 0));
    check("wr_err", 32'(wr_err), 32'(m_wr_err));
    acc = v && (req_ready === 1'b1);
    drain = (busy == 0) && (pend > 0);
    if (busy > 0) busy--;
    if (drain) pend--;
    if (acc) begin
      i = int'(a[9:2]);
      o = |a[31:10];
      if (we) begin
        if (o) m_wr_err = 1;
        else begin
          for (int b = 0; b < 4; b++) if (be[b]) m_mem[i][8*b+:8] = d[8*b+:8];
          if (be == 4'hF) m_wr[i] = 1;
          pend++;
        end
      end else begin
        busy = L;
        exp_err = o;
        exp_known = o || m_wr[i];
        exp_data = o ? 32'h0 : m_mem[i];
      end
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, acc);
  endtask

  task automatic do_req(input bit we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    bit acc;
    for (int t = 0; t < 20; t++) begin
      cycle(1, we, a, be, d, acc);
      if (acc) return;
    end
    check("req_timeout", 0, 1);
  endtask

  task automatic load_expect(input string tag, input logic [31:0] a, input logic [31:0] val);
    got_rsp = 0;
    do_req(0, a, 0, 0);
    for (int t = 0; t < 10 && !got_rsp; t++) idle(1);
    check({tag, "_seen"}, 32'(got_rsp), 1);
    check(tag, last_rdata, val);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; req_valid = 0; req_we = 0;
    #1;
    check("rst_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_wbuf_empty", 32'(wbuf_empty), 1);
    check("rst_wr_err", 32'(wr_err), 0);
    pend = 0; busy = 0; m_wr_err = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          i;
    logic [31:0] a;
    do_reset();
    // Store then dependent load: ready waits for the drain, data after L edges.
    do_req(1, 32'd96, 4'hF, 32'd7);
    load_expect("t1_load", 32'd96, 32'd7);
    check("t1_err", 32'(last_err), 0);
    do_req(1, 32'd100, 4'hF, 32'h11223344);
    do_req(1, 32'd100, 4'b0001, 32'h000000AA);
    load_expect("t2_merge", 32'd100, 32'h112233AA);
    for (int k = 0; k < 5; k++) do_req(1, 32'd104 + 32'(4 * k), 4'hF, 32'hC0DE0000 + 32'(k));
    for (int k = 0; k < 5; k++) load_expect("t3_load", 32'd104 + 32'(4 * k), 32'hC0DE0000 + 32'(k));
    do_req(0, 32'd96, 0, 0);
    do_req(0, 32'd100, 0, 0);
    idle(L + 2);
    load_expect("t5_oor_data", 32'h0000_1000, 32'h0);
    check("t5_oor_err", 32'(last_err), 1);
    do_req(1, 32'h0000_1000, 4'hF, 32'hDEADBEEF);
    idle(3);
    check("t5_wr_err_sticky", 32'(wr_err), 1);
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(3) == 0) idle(1);
      else begin
        i = ($urandom_range(1) == 0) ? int'($urandom_range(15)) : 96 + int'($urandom_range(7));
        a = {22'h0, i[7:0], 2'($urandom_range(3))};
        if ($urandom_range(15) == 0) a[12] = 1'b1;
        if ($urandom_range(1) == 0) do_req(0, a, 0, 0);
        else do_req(1, a, m_wr[i] ? 4'($urandom_range(15)) : 4'hF, $urandom);
      end
    end
    idle(L + 2);
    // Reset in the middle of a load: no response, earlier drained data survives.
    do_req(1, 32'd100, 4'hF, 32'd25);
    idle(3);
    do_req(0, 32'd100, 0, 0);
    do_reset();
    idle(L + 3);
    load_expect("t6_after_reset", 32'd100, 32'd25);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
